// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS decode stage (RF, imm extender, load-use hazard unit) with ID/EX register.
// Optional WB->ID same-cycle bypass when ID_BYPASS_EN is defined.
module id_stage_hz #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter logic [DATA_WIDTH-1:0] RST_PC     = '0
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] pc_plus4_in,
    input  logic [31:0]           instr_in,
    input  logic                  ext_ctrl,
    input  logic                  reg_wr_en,
    input  logic [4:0]            reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  ex_load,
    input  logic [4:0]            ex_rd_addr,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall_out,
    output logic [4:0]            regS_addr_id,
    output logic [4:0]            regT_addr_id,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] pc_plus4_out,
    output logic [DATA_WIDTH-1:0] regA_rd_data,
    output logic [DATA_WIDTH-1:0] regB_rd_data,
    output logic [DATA_WIDTH-1:0] imm_exted,
    output logic [4:0]            regS_addr,
    output logic [4:0]            regT_addr,
    output logic [4:0]            regD_addr
);
    logic [DATA_WIDTH-1:0] rf [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_a, rf_b, rd_a, rd_b, imm;
    logic [4:0]            rs, rt, rd;
    logic                  load_use;

    assign rs = instr_in[25:21];
    assign rt = instr_in[20:16];
    assign rd = instr_in[15:11];
    assign regS_addr_id = rs;
    assign regT_addr_id = rt;

    genvar g;
    for (g = 0; g < NUM_REGS; g++) begin : g_rf
        always_ff @(posedge clk or negedge rstb)
            if (!rstb)
                rf[g] <= '0;
            else if (g != 0 && reg_wr_en && reg_wr_addr == 5'(g))
                rf[g] <= reg_wr_data;
    end

    // R0 and out-of-range addresses fall through to zero
    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs == 5'(i)) rf_a = rf[i];
            if (rt == 5'(i)) rf_b = rf[i];
        end
    end

`ifdef ID_BYPASS_EN
    logic wr_ok;
    assign wr_ok = reg_wr_en && reg_wr_addr != 5'd0 && {27'd0, reg_wr_addr} < NUM_REGS;
    assign rd_a  = (wr_ok && reg_wr_addr == rs) ? reg_wr_data : rf_a;
    assign rd_b  = (wr_ok && reg_wr_addr == rt) ? reg_wr_data : rf_b;
`else
    assign rd_a = rf_a;
    assign rd_b = rf_b;
`endif

    assign imm = ext_ctrl ? {{(DATA_WIDTH-16){instr_in[15]}}, instr_in[15:0]}
                          : {{(DATA_WIDTH-16){1'b0}}, instr_in[15:0]};

    assign load_use  = in_valid && ex_load && ex_rd_addr != 5'd0 && (ex_rd_addr == rs || ex_rd_addr == rt);
    assign stall_out = (load_use || hold) && !flush;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            out_valid    <= 1'b0;
            pc_plus4_out <= RST_PC;
            regA_rd_data <= '0;
            regB_rd_data <= '0;
            imm_exted    <= '0;
            regS_addr    <= '0;
            regT_addr    <= '0;
            regD_addr    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!hold) begin
            if (load_use) begin
                out_valid <= 1'b0;
                regS_addr <= '0;
                regT_addr <= '0;
                regD_addr <= '0;
            end else begin
                out_valid    <= in_valid;
                pc_plus4_out <= pc_plus4_in;
                regA_rd_data <= rd_a;
                regB_rd_data <= rd_b;
                imm_exted    <= imm;
                regS_addr    <= rs;
                regT_addr    <= rt;
                regD_addr    <= rd;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed + randomized check of id_stage_hz against a behavioural model.
module tb_id_stage_hz;
    localparam int          DW = 32;
    localparam int          NR = 24;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          in_valid = 0, ext_ctrl = 0, reg_wr_en = 0, ex_load = 0, hold = 0, flush = 0;
    logic [DW-1:0] pc_plus4_in = '0, reg_wr_data = '0;
    logic [31:0]   instr_in = '0;
    logic [4:0]    reg_wr_addr = '0, ex_rd_addr = '0;
    logic          stall_out, out_valid;
    logic [4:0]    regS_addr_id, regT_addr_id, regS_addr, regT_addr, regD_addr;
    logic [DW-1:0] pc_plus4_out, regA_rd_data, regB_rd_data, imm_exted;

    id_stage_hz #(.DATA_WIDTH(DW), .NUM_REGS(NR), .RST_PC(RPC)) dut (
        .clk(clk), .rstb(rstb), .in_valid(in_valid), .pc_plus4_in(pc_plus4_in),
        .instr_in(instr_in), .ext_ctrl(ext_ctrl), .reg_wr_en(reg_wr_en),
        .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .ex_load(ex_load),
        .ex_rd_addr(ex_rd_addr), .hold(hold), .flush(flush), .stall_out(stall_out),
        .regS_addr_id(regS_addr_id), .regT_addr_id(regT_addr_id), .out_valid(out_valid),
        .pc_plus4_out(pc_plus4_out), .regA_rd_data(regA_rd_data), .regB_rd_data(regB_rd_data),
        .imm_exted(imm_exted), .regS_addr(regS_addr), .regT_addr(regT_addr), .regD_addr(regD_addr)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    logic [31:0] m_rf [32];
    logic        e_valid;
    logic [31:0] e_pc, e_a, e_b, e_imm;
    logic [4:0]  e_s, e_t, e_d;
    logic [31:0] snap;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (a == 0 || int'(a) >= NR) return 32'd0;
`ifdef ID_BYPASS_EN
        if (reg_wr_en && reg_wr_addr == a) return reg_wr_data;
`endif
        return m_rf[a];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [10:0] lo);
        return {6'd0, s, t, d, lo};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        e_valid = 0; e_pc = RPC; e_a = 0; e_b = 0; e_imm = 0; e_s = 0; e_t = 0; e_d = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e_valid});
        chk({tag, ".rs"}, {27'd0, regS_addr}, {27'd0, e_s});
        chk({tag, ".rt"}, {27'd0, regT_addr}, {27'd0, e_t});
        chk({tag, ".rd"}, {27'd0, regD_addr}, {27'd0, e_d});
        if (e_valid) begin
            chk({tag, ".pc"}, pc_plus4_out, e_pc);
            chk({tag, ".a"}, regA_rd_data, e_a);
            chk({tag, ".b"}, regB_rd_data, e_b);
            chk({tag, ".imm"}, imm_exted, e_imm);
        end
    endtask

    // Inputs are set after a negedge; this checks the decode-side outputs, clocks once and checks ID/EX.
    task automatic cycle(input string tag);
        logic [4:0] s, t;
        logic lu;
        s = instr_in[25:21];
        t = instr_in[20:16];
        lu = in_valid && ex_load && ex_rd_addr != 0 && (ex_rd_addr == s || ex_rd_addr == t);
        #1;
        chk({tag, ".stall"}, {31'd0, stall_out}, {31'd0, (lu || hold) && !flush});
        chk({tag, ".rs_id"}, {27'd0, regS_addr_id}, {27'd0, s});
        chk({tag, ".rt_id"}, {27'd0, regT_addr_id}, {27'd0, t});
        if (flush) e_valid = 0;
        else if (hold) ;
        else if (lu) begin
            e_valid = 0; e_s = 0; e_t = 0; e_d = 0;
        end else begin
            e_valid = in_valid; e_pc = pc_plus4_in;
            e_a = ref_rd(s); e_b = ref_rd(t);
            e_imm = ext_ctrl ? 32'(signed'(instr_in[15:0])) : {16'd0, instr_in[15:0]};
            e_s = s; e_t = t; e_d = instr_in[15:11];
        end
        if (reg_wr_en && reg_wr_addr != 0 && int'(reg_wr_addr) < NR) m_rf[reg_wr_addr] = reg_wr_data;
        @(posedge clk);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; ext_ctrl = 0; reg_wr_en = 0; ex_load = 0; hold = 0; flush = 0;
        pc_plus4_in = '0; reg_wr_data = '0; instr_in = '0; reg_wr_addr = '0; ex_rd_addr = '0;
    endtask

    initial begin
        model_reset();
        idle();
        #12;
        check_regs("reset");
        chk("reset.pc", pc_plus4_out, RPC);
        @(negedge clk);
        rstb = 1;

        // R5 = 0x1234, then ADD rs=5
        reg_wr_en = 1; reg_wr_addr = 5; reg_wr_data = 32'h1234;
        cycle("t1w");
        idle();
        in_valid = 1; pc_plus4_in = 32'h44; instr_in = mk(5, 6, 10, 11'h20);
        cycle("t1");
        chk("t1.regA", regA_rd_data, 32'h1234);
        chk("t1.valid1", {31'd0, out_valid}, 32'd1);

        // Same-cycle WB write and ID read of R7
        idle();
        reg_wr_en = 1; reg_wr_addr = 7; reg_wr_data = 32'h55;
        cycle("t2w");
        reg_wr_data = 32'hAA; in_valid = 1; instr_in = mk(7, 0, 1, 0);
        cycle("t2");
`ifdef ID_BYPASS_EN
        chk("t2.bypass", regA_rd_data, 32'hAA);
`else
        chk("t2.nobypass", regA_rd_data, 32'h55);
`endif

        // Load-use on rt: one-cycle stall and bubble, then issue
        idle();
        in_valid = 1; pc_plus4_in = 32'h50; instr_in = mk(1, 3, 9, 0); ex_load = 1; ex_rd_addr = 3;
        cycle("t3a");
        chk("t3.bubble", {31'd0, out_valid}, 32'd0);
        ex_load = 0;
        cycle("t3b");
        chk("t3.issue", {31'd0, out_valid}, 32'd1);

        // flush overrides load-use
        ex_load = 1; flush = 1;
        cycle("t4");
        chk("t4.valid", {31'd0, out_valid}, 32'd0);

        // hold for 3 cycles freezes ID/EX
        idle();
        in_valid = 1; pc_plus4_in = 32'h60; instr_in = mk(5, 7, 2, 11'h3);
        cycle("t5l");
        snap = regA_rd_data;
        hold = 1; pc_plus4_in = 32'h64; instr_in = mk(1, 2, 3, 11'h7FF);
        for (int i = 0; i < 3; i++) begin
            cycle("t5h");
            chk("t5.hold_a", regA_rd_data, snap);
        end
        hold = 0;

        // Extender and R0
        idle();
        in_valid = 1; instr_in = {16'd0, 16'h8000}; ext_ctrl = 1; reg_wr_en = 1; reg_wr_addr = 0; reg_wr_data = 5;
        cycle("t6s");
        chk("t6.sext", imm_exted, 32'hFFFF8000);
        ext_ctrl = 0; reg_wr_en = 0;
        cycle("t6z");
        chk("t6.zext", imm_exted, 32'h00008000);
        chk("t6.r0", regA_rd_data, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid = ($urandom_range(0, 7) != 0);
            pc_plus4_in = $urandom;
            instr_in = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                instr_in[25:21] = 5'($urandom_range(0, 7));
                instr_in[20:16] = 5'($urandom_range(0, 7));
            end
            ext_ctrl = 1'($urandom);
            reg_wr_en = 1'($urandom);
            reg_wr_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            reg_wr_data = $urandom;
            ex_load = ($urandom_range(0, 2) == 0);
            ex_rd_addr = 5'($urandom_range(0, 7));
            hold = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            cycle("rnd");
        end

        // Asynchronous reset in the middle of a load-use stall
        idle();
        in_valid = 1; instr_in = mk(4, 2, 1, 0); ex_load = 1; ex_rd_addr = 4;
        #2;
        rstb = 0;
        #1;
        model_reset();
        check_regs("mrst");
        chk("mrst.pc", pc_plus4_out, RPC);
        chk("mrst.stall", {31'd0, stall_out}, 32'd1);
        @(negedge clk);
        rstb = 1;
        ex_load = 0;
        cycle("post");
        chk("post.rf", regA_rd_data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
